outbus_arb: RTL
===============

# outbus_arb

Round-robin arbiter sharing one downstream simple-bus port (`outaddr`/`outreq`/`outack` handshake, as driven by the AXI3 slave bridge) between `N` requesters, e.g. the AXI3 bridge, a DMA engine and a debug port. It holds a grant until the downstream acknowledges, then rotates priority. A watchdog terminates hung accesses with an error so one dead slave cannot lock out the other requesters.

## Interface
- `N`, 2: number of requesters (2..4).
- `ADDR`, 32: address width.
- `DATA`, 32: data width, a multiple of 8.
- `TIMEBITS`, 20: watchdog counter width.
- `TIMEOUT`, 1048575: watchdog reload value in cycles; 0 disables the watchdog.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `reqaddr` in N*ADDR: per-requester address; requester i occupies bits [i*ADDR +: ADDR].
- `reqwdata` in N*DATA: per-requester write data.
- `reqwstrb` in N*DATA/8: per-requester byte strobes.
- `reqwr` in N: per-requester write flag.
- `reqreq` in N: per-requester request; held high until that requester's `reqack`.
- `reqack` out N: one-hot completion pulse.
- `reqerr` out N: error qualifier, valid with `reqack`.
- `reqrdata` out DATA: read data broadcast to all requesters, valid with `reqack`.
- `outaddr` out ADDR, `outwdata` out DATA, `outwstrb` out DATA/8, `outwr` out 1, `outreq` out 1: downstream request.
- `outack` in 1, `outerr` in 1, `outrdata` in DATA: downstream response.

## Operation
- Registered state: `state` (IDLE, BUSY), `grant` (log2 N bits), `last` (index of the most recent grant), `timer` (TIMEBITS bits).
- IDLE:
  - `outreq` = 0.
  - If any `reqreq` bit is set, pick the first set bit scanning `last+1, last+2, …` modulo N.
  - Load `grant` and `last` with that index, load `timer` with TIMEOUT, and go to BUSY.
- BUSY:
  - `outreq` = 1.
  - `outaddr`, `outwdata`, `outwstrb` and `outwr` are muxed combinationally from slice `grant`.
- Completion occurs on `outack`, or on `timer`==0 when TIMEOUT≠0. In that cycle:
  - `reqack[grant]` = 1.
  - `reqerr[grant]` = `outerr` on a normal ack; 1 on a timeout with no `outack` (`outack` has priority when both occur).
  - Next state is IDLE.
- Abort: if `reqreq[grant]` is 0 in BUSY without completion, go to IDLE with no `reqack`.
- `reqrdata` = `outrdata` at all times. Requesters sample it only with their `reqack`.
- `timer` decrements by 1 each BUSY cycle while nonzero and saturates at 0.
- When idle, `outaddr`/`outwdata`/`outwstrb` are don't-care and `outwr` = 0.
- Reset, asynchronous, takes effect mid-transaction too:
  - `state` = IDLE, `last` = N-1 so requester 0 wins first, `grant` = 0, `timer` = 0.
  - All of `outreq`, `outwr`, `reqack` and `reqerr` go to 0 immediately.

## Timing
- Arbitration latency: request visible in cycle t gives `outreq` = 1 in cycle t+1.
- `reqack` is combinational from `outack` and is asserted in the same cycle as `outack`.
- Minimum one IDLE cycle between consecutive grants, so peak throughput is one access per 2 cycles with a zero-wait slave.
- Requesters must drop `reqreq` the cycle after `reqack`. A requester still asserting in the following IDLE cycle is treated as a new request and competes under rotation.
- Downstream signals are stable for the whole BUSY interval: `grant` does not change during BUSY, and requesters hold their inputs while requesting.
- A watchdog expiry occurs after TIMEOUT+1 BUSY cycles without `outack`.
- No combinational path from `reqreq` to `outreq`.

## Test plan
- N=2, requester 0 reads 0x100 alone, slave acks 2 cycles after `outreq` with `outrdata`=0xDEADBEEF, `outerr`=0 -> one `reqack[0]` pulse, `reqrdata`=0xDEADBEEF, `reqerr[0]`=0, `outwr`=0.
- Requesters 0 and 1 request in the same cycle after reset -> requester 0 is served first. Both re-request continuously -> grant order 0,1,0,1 and no starvation. N=4 with all requesting -> order 0,1,2,3,0.
- Requester 1 writes 0x20 with `reqwdata`=0x12345678, `reqwstrb`=0x3; slave acks with `outerr`=1 -> downstream sees exactly that address/data/strobe with `outwr`=1; `reqack[1]` and `reqerr[1]` are 1; `reqack[0]` stays 0.
- TIMEOUT=5, slave never acks -> `outreq` is high for exactly 6 cycles, then `reqack` and `reqerr` pulse for the granted requester, and the other pending requester is granted next.
- `resetn` pulled low during BUSY -> `outreq` drops immediately. After release, requester 0 is granted first regardless of the grant history before reset.
- Requester drops `reqreq` during BUSY without an ack -> `outreq` is low the next cycle, no `reqack` is generated, and the arbiter returns to IDLE.

Source files
------------

// File: rtl/outbus_arb.sv
// outbus_arb: round-robin arbiter sharing one simple-bus downstream port among N requesters, with watchdog
//   clk, resetn                            : clock, async active-low reset
//   reqaddr/reqwdata/reqwstrb/reqwr/reqreq : per-requester request slices
//   reqack/reqerr/reqrdata                 : completion pulse, error, broadcast read data
//   outaddr/outwdata/outwstrb/outwr/outreq : downstream request
//   outack/outerr/outrdata                 : downstream response
module outbus_arb #(
  parameter int N        = 2,
  parameter int ADDR     = 32,
  parameter int DATA     = 32,
  parameter int TIMEBITS = 20,
  parameter int TIMEOUT  = 1048575
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N*ADDR-1:0]      reqaddr,
  input  logic [N*DATA-1:0]      reqwdata,
  input  logic [N*(DATA/8)-1:0]  reqwstrb,
  input  logic [N-1:0]           reqwr,
  input  logic [N-1:0]           reqreq,
  output logic [N-1:0]           reqack,
  output logic [N-1:0]           reqerr,
  output logic [DATA-1:0]        reqrdata,
  output logic [ADDR-1:0]        outaddr,
  output logic [DATA-1:0]        outwdata,
  output logic [DATA/8-1:0]      outwstrb,
  output logic                   outwr,
  output logic                   outreq,
  input  logic                   outack,
  input  logic                   outerr,
  input  logic [DATA-1:0]        outrdata
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DATA / 8;
  localparam logic [TIMEBITS-1:0] TLOAD = TIMEBITS'(TIMEOUT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick, cand;
  logic [TIMEBITS-1:0] timer_q, timer_d;
  logic found, busy, done;
  assign busy = state_q == BUSY;
  // outack wins over a simultaneous watchdog expiry; TIMEOUT of 0 disables the watchdog
  assign done = busy && (outack || (TIMEOUT != 0 && timer_q == '0));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N - 1);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = last_q;
    // scan last+1, last+2, ... so the most recent winner has lowest priority
    for (int k = 1; k <= N; k++) begin
      cand = GW'((int'(last_q) + k) % N);
      if (!found && reqreq[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    if (!busy) begin
      if (found) begin
        state_d = BUSY;
        grant_d = pick;
        last_d  = pick;
        timer_d = TLOAD;
      end
    end else begin
      timer_d = (timer_q == '0) ? '0 : timer_q - 1'b1;
      // completion or a withdrawn request both end the access
      if (done || !reqreq[grant_q]) state_d = IDLE;
    end
  end
  always_comb begin
    outreq   = busy;
    outaddr  = reqaddr[int'(grant_q)*ADDR +: ADDR];
    outwdata = reqwdata[int'(grant_q)*DATA +: DATA];
    outwstrb = reqwstrb[int'(grant_q)*SW +: SW];
    outwr    = busy & reqwr[grant_q];
    reqrdata = outrdata;
    reqack   = '0;
    reqerr   = '0;
    if (done) begin
      reqack[grant_q] = 1'b1;
      reqerr[grant_q] = outack ? outerr : 1'b1;
    end
  end
endmodule
